fpu_issue_sequencer: RTL and testbench

Upstream feeder and downstream collector for the free-running 6-cycle FPU adder. It accepts operand pairs over a valid/ready handshake and drives `op_a`/`op_b` stable across each FPU sampling edge. A phase counter runs in lockstep with the FPU state machine. The block captures `data_out`/`status_out` only for slots that carried real operands, and buffers those results in a small FIFO for a valid/ready consumer.

---
 rtl/fpu_issue_sequencer.sv | 149 ++++++++++++++
 tb/tb_fpu_issue_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_sequencer.sv
// Feeds operand pairs to the free-running 6-cycle FPU adder in lockstep with its state machine,
// and collects the results of occupied slots into a small in-order FIFO.
module fpu_issue_sequencer #(
  parameter int RES_DEPTH = 4
) (
  input  logic        clock_100k,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  input  logic [31:0] fpu_data,
  input  logic [3:0]  fpu_status,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [3:0]  res_status,
  output logic        busy
);
  localparam int PW = $clog2(RES_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(RES_DEPTH);

  logic [2:0]    p_q, p_d;
  logic          pend_valid_q, pend_valid_d;
  logic [31:0]   pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic [31:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic          issue_tag_q, issue_tag_d;
  logic          flight_tag_q, flight_tag_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [35:0]   mem_q [RES_DEPTH];

  logic          accept_s, pop_s, push_s, issue_s;
  logic [CW:0]   used_s;

  assign accept_s = in_valid && !pend_valid_q;
  assign pop_s    = (count_q != {CW{1'b0}}) && res_ready;
  assign push_s   = (p_q == 3'd0) && flight_tag_q;
  // Credit counts buffered entries plus the slot about to be captured; a same-edge pop is ignored.
  assign used_s   = {1'b0, count_q} + {{CW{1'b0}}, flight_tag_q};
  assign issue_s  = (p_q == 3'd5) && pend_valid_q && (used_s < DEPTH_W);

  // Next-state logic for phase, pending pair, FPU operands, slot tags and FIFO bookkeeping.
  always_comb begin
    p_d          = (p_q == 3'd5) ? 3'd0 : p_q + 3'd1;
    pend_valid_d = pend_valid_q;
    pend_a_d     = pend_a_q;
    pend_b_d     = pend_b_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    issue_tag_d  = issue_tag_q;
    flight_tag_d = flight_tag_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    if (issue_s) begin
      pend_valid_d = 1'b0;
    end else if (accept_s) begin
      pend_valid_d = 1'b1;
      pend_a_d     = in_a;
      pend_b_d     = in_b;
    end else begin
      pend_valid_d = pend_valid_q;
    end

    // Operands only move at the edge just before the FPU samples them; idle slots add 0+0.
    if (p_q == 3'd5) begin
      issue_tag_d = issue_s;
      if (issue_s) begin
        op_a_d = pend_a_q;
        op_b_d = pend_b_q;
      end else begin
        op_a_d = 32'd0;
        op_b_d = 32'd0;
      end
    end else begin
      issue_tag_d = issue_tag_q;
    end

    if (p_q == 3'd0) begin
      flight_tag_d = issue_tag_q;
    end else begin
      flight_tag_d = flight_tag_q;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // State registers; the reset net is shared with the FPU so phase lockstep survives a reset.
  always_ff @(posedge clock_100k or negedge reset) begin
    if (!reset) begin
      p_q          <= 3'd0;
      pend_valid_q <= 1'b0;
      pend_a_q     <= 32'd0;
      pend_b_q     <= 32'd0;
      op_a_q       <= 32'd0;
      op_b_q       <= 32'd0;
      issue_tag_q  <= 1'b0;
      flight_tag_q <= 1'b0;
      wr_ptr_q     <= {PW{1'b0}};
      rd_ptr_q     <= {PW{1'b0}};
      count_q      <= {CW{1'b0}};
      for (int i = 0; i < RES_DEPTH; i++) begin
        mem_q[i] <= 36'd0;
      end
    end else begin
      p_q          <= p_d;
      pend_valid_q <= pend_valid_d;
      pend_a_q     <= pend_a_d;
      pend_b_q     <= pend_b_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      issue_tag_q  <= issue_tag_d;
      flight_tag_q <= flight_tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      if (push_s) begin
        mem_q[wr_ptr_q] <= {fpu_data, fpu_status};
      end
    end
  end

  assign in_ready               = !pend_valid_q;
  assign op_a                   = op_a_q;
  assign op_b                   = op_b_q;
  assign res_valid              = (count_q != {CW{1'b0}});
  assign {res_data, res_status} = mem_q[rd_ptr_q];
  assign busy                   = pend_valid_q | issue_tag_q | flight_tag_q | res_valid;

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// Bench for fpu_issue_sequencer: a behavioural 6-state FPU stub plus a result scoreboard.
module tb_fpu_issue_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, res_valid, res_ready, busy;
  logic [31:0] in_a, in_b, op_a, op_b, res_data;
  logic [3:0]  res_status;
  logic [2:0]  fs;
  logic [31:0] sa, sb, fpu_data;
  logic [3:0]  fpu_status;

  int checks = 0;
  int passed = 0;
  logic [31:0] send_q[$];
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  fpu_issue_sequencer #(.RES_DEPTH(4)) dut (
    .clock_100k(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .op_a(op_a), .op_b(op_b),
    .fpu_data(fpu_data), .fpu_status(fpu_status), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_status(res_status), .busy(busy)
  );

  // x + x doubles a normal number (exponent + 1, exact); zero + zero stays zero.
  function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b);
    if (a != b) model_sum = 32'h7FF80000;
    else if (a[30:0] == 31'd0) model_sum = a;
    else model_sum = {a[31], a[30:20] + 11'd1, a[19:0]};
  endfunction

  function automatic logic [3:0] model_stat(input logic [31:0] a, input logic [31:0] b);
    model_stat = (a == b) ? 4'b1000 : 4'b0001;
  endfunction

  function automatic logic [31:0] pat(input int k);
    pat = {1'b0, 11'(1000 + k), 20'(k * 12345)};
  endfunction

  // FPU stub: samples at state 0, writes at state 5, output is garbage outside its valid window.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs <= 3'd0; sa <= 32'd0; sb <= 32'd0; fpu_data <= 32'd0; fpu_status <= 4'd0;
    end else begin
      fs <= (fs == 3'd5) ? 3'd0 : fs + 3'd1;
      if (fs == 3'd0) begin
        sa <= op_a; sb <= op_b; fpu_data <= 32'hBAD0BAD0; fpu_status <= 4'b0110;
      end else if (fs == 3'd5) begin
        fpu_data <= model_sum(sa, sb); fpu_status <= model_stat(sa, sb);
      end
    end
  end

  task automatic wait_phase(input logic [2:0] ph);
    for (int i = 0; i < 6; i++) if (fs != ph) @(negedge clk);
  endtask

  // Drives the next queued pair; in_ready is stable until the coming edge, so an offer is an accept.
  task automatic offer_step(input bit en);
    logic [31:0] x;
    if (en && send_q.size() > 0 && in_ready) begin
      x = send_q.pop_front();
      in_valid = 1'b1; in_a = x; in_b = x;
      exp_q.push_back({model_sum(x, x), model_stat(x, x)});
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; res_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({in_ready, res_valid, busy} !== 3'b100) $display("FAIL reset_ctrl: got %b want 100", {in_ready, res_valid, busy}); else passed++;
    checks++; if ({op_a, op_b} !== 64'd0) $display("FAIL reset_ops: got %h %h want 0", op_a, op_b); else passed++;
    checks++; if ({res_data, res_status} !== 36'd0) $display("FAIL reset_res: got %h want 0", {res_data, res_status}); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_single_add(input string tag);
    bit bad = 1'b0;
    wait_phase(3'd4);
    checks++; if (in_ready !== 1'b1) $display("FAIL %s_ready: got %b want 1", tag, in_ready); else passed++;
    in_valid = 1'b1; in_a = 32'h3FF00000; in_b = 32'h3FF00000;
    @(negedge clk); in_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++; if (res_valid !== (i == 8)) $display("FAIL %s_latency: after A+%0d res_valid=%b want %b", tag, i, res_valid, (i == 8)); else passed++;
    end
    checks++; if ({res_data, res_status} !== {32'h40000000, 4'b1000}) $display("FAIL %s_data: got %h/%b want 40000000/1000", tag, res_data, res_status); else passed++;
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    repeat (14) begin if (res_valid) bad = 1'b1; @(negedge clk); end
    checks++; if (bad) $display("FAIL %s_single: extra result seen, want exactly one", tag); else passed++;
  endtask

  task automatic test_worst_latency();
    logic [31:0] exp_op;
    wait_phase(3'd5);
    in_valid = 1'b1; in_a = 32'h3FF00000; in_b = 32'h3FF00000;
    @(negedge clk); in_valid = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      exp_op = (i >= 6 && i < 12) ? 32'h3FF00000 : 32'd0;
      checks++; if ({op_a, op_b, res_valid} !== {exp_op, exp_op, (i == 13)}) $display("FAIL worst_lat: after A+%0d op_a=%h op_b=%h res_valid=%b want %h %h %b", i, op_a, op_b, res_valid, exp_op, exp_op, (i == 13)); else passed++;
    end
    checks++; if ({res_data, res_status} !== {32'h40000000, 4'b1000}) $display("FAIL worst_data: got %h/%b want 40000000/1000", res_data, res_status); else passed++;
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++; if ({res_valid, busy, op_a, op_b} !== 66'd0) $display("FAIL idle: cycle %0d res_valid=%b busy=%b op_a=%h op_b=%h want all 0", i, res_valid, busy, op_a, op_b); else passed++;
    end
  endtask

  task automatic test_back_pressure();
    logic [35:0] e;
    int n = 0;
    res_ready = 1'b0;
    repeat (6) send_q.push_back(32'h3FF00000);
    repeat (80) begin offer_step(1'b1); @(negedge clk); end
    in_valid = 1'b0;
    checks++; if ({in_ready, res_valid, busy} !== 3'b011) $display("FAIL bp_hold: in_ready/res_valid/busy=%b want 011", {in_ready, res_valid, busy}); else passed++;
    checks++; if (send_q.size() != 1) $display("FAIL bp_accepted: got %0d want 5", 6 - send_q.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      res_ready = 1'b1;
      e = exp_q.pop_front();
      checks++; if ({res_valid, res_data, res_status} !== {1'b1, e}) $display("FAIL bp_buffered: pop %0d got %b %h want 1 %h", i, res_valid, {res_data, res_status}, e); else passed++;
      @(negedge clk);
    end
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0) $display("FAIL bp_depth: res_valid=%b after 4 pops want 0", res_valid); else passed++;
    while (exp_q.size() > 0 && n < 60) begin
      offer_step(1'b1); res_ready = 1'b1;
      if (res_valid) begin
        e = exp_q.pop_front();
        checks++; if ({res_data, res_status} !== e) $display("FAIL bp_drain: got %h want %h", {res_data, res_status}, e); else passed++;
      end
      @(negedge clk); n++;
    end
    in_valid = 1'b0; res_ready = 1'b0;
    checks++; if (exp_q.size() != 0 || send_q.size() != 0 || res_valid !== 1'b0) $display("FAIL bp_complete: missing %0d unsent %0d res_valid=%b want 0 0 0", exp_q.size(), send_q.size(), res_valid); else passed++;
  endtask

  task automatic test_push_pop();
    logic [35:0] e;
    int n = 0;
    res_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send_q.push_back(pat(k));
    while (!res_valid && n < 60) begin offer_step(1'b1); @(negedge clk); n++; end
    checks++; if (res_valid !== 1'b1) $display("FAIL pp_timeout: res_valid=%b want 1", res_valid); else passed++;
    repeat (17) begin offer_step(1'b1); @(negedge clk); end
    // The coming edge captures the fourth result while the head is popped.
    res_ready = 1'b1;
    e = exp_q.pop_front();
    checks++; if ({res_valid, res_data, res_status} !== {1'b1, e}) $display("FAIL pp_head: got %b %h want 1 %h", res_valid, {res_data, res_status}, e); else passed++;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      checks++; if ({res_valid, res_data, res_status} !== {1'b1, e}) $display("FAIL pp_order: pop %0d got %b %h want 1 %h", i, res_valid, {res_data, res_status}, e); else passed++;
      @(negedge clk);
    end
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0) $display("FAIL pp_count: res_valid=%b after 4 pops want 0", res_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [35:0] e;
    int got = 0;
    int n = 0;
    for (int k = 10; k < 22; k++) send_q.push_back(pat(k));
    while (got < 12 && n < 600) begin
      offer_step($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 2) != 0);
      if (res_valid && res_ready) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL b2b_extra: got %h want none", {res_data, res_status});
        else begin
          e = exp_q.pop_front();
          if ({res_data, res_status} !== e) $display("FAIL b2b_data: result %0d got %h want %h", got, {res_data, res_status}, e); else passed++;
        end
        got++;
      end
      @(negedge clk); n++;
    end
    in_valid = 1'b0; res_ready = 1'b0;
    checks++; if (got != 12 || exp_q.size() != 0) $display("FAIL b2b_count: got %0d results want 12 (left %0d)", got, exp_q.size()); else passed++;
  endtask

  task automatic test_mid_reset();
    int n = 0;
    res_ready = 1'b0;
    for (int k = 30; k < 33; k++) send_q.push_back(pat(k));
    while (!res_valid && n < 60) begin offer_step(1'b1); @(negedge clk); n++; end
    repeat (6) begin offer_step(1'b1); @(negedge clk); end
    in_valid = 1'b0;
    wait_phase(3'd3);
    checks++; if ({res_valid, busy} !== 2'b11) $display("FAIL mr_pre: res_valid/busy=%b want 11", {res_valid, busy}); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if ({in_ready, res_valid, busy} !== 3'b100) $display("FAIL mr_ctrl: got %b want 100", {in_ready, res_valid, busy}); else passed++;
    checks++; if ({op_a, op_b, res_data, res_status} !== 100'd0) $display("FAIL mr_data: op_a=%h op_b=%h res=%h want 0", op_a, op_b, {res_data, res_status}); else passed++;
    exp_q.delete(); send_q.delete();
    @(negedge clk); rst_n = 1'b1;
    test_single_add("post_reset");
  endtask

  initial begin
    test_reset();
    test_single_add("single");
    test_worst_latency();
    test_idle();
    test_back_pressure();
    test_push_pop();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
